// File: rtl/dither_duty_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : dither_duty_sched_if
// Description : Valid/ready duty-command bus into the dither duty scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface dither_duty_sched_if #(
    parameter int NPH = 4,
    parameter int DW  = 10
) ();
    logic           cmd_valid;
    logic           cmd_ready;
    logic [DW-1:0]  cmd_duty;
    logic [NPH-1:0] cmd_phase_en;

    modport master (
        output cmd_valid,
        output cmd_duty,
        output cmd_phase_en,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        input  cmd_phase_en,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/dither_duty_sched.sv
`default_nettype none
// ============================================================================
// Module      : dither_duty_sched
// Description : Slew-limited, frame-aligned duty scheduler feeding NPH dither
//               instances over per-phase duty buses.
// Revision    : 1.0 - initial release
// ============================================================================
module dither_duty_sched #(
    parameter int NPH      = 4,
    parameter int DW       = 10,
    parameter int MAX_STEP = 8,
    parameter int DMAX     = 1000
) (
    input  wire logic              clk_in,
    input  wire logic              rst,
    dither_duty_sched_if.slave     cmd,
    output logic [NPH*DW-1:0]      d_n_out,
    output logic [NPH-1:0]         phase_en_out,
    output logic                   frame_tick,
    output logic                   busy
);

    localparam logic [DW:0] c_max_step = (DW+1)'(MAX_STEP);
    localparam logic [DW:0] c_dmax     = (DW+1)'(DMAX);
    localparam logic [2:0]  c_last_cyc = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SLEW = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_fcnt;
    logic [DW-1:0]     r_cur;
    logic [DW-1:0]     r_target;
    logic [NPH-1:0]    r_pend_en;
    logic [NPH-1:0]    r_phase_en;
    logic [NPH*DW-1:0] r_d_n;

    logic              w_tick;
    logic              w_ready;
    logic              w_xfer;
    logic              w_apply;
    logic              w_reached;
    logic [DW-1:0]     w_cmd_clamped;
    logic [DW-1:0]     w_cur_step;
    logic [DW:0]       w_cur_x;
    logic [DW:0]       w_tgt_x;
    logic [DW:0]       w_step_x;
    logic [NPH*DW-1:0] w_d_n_nxt;

    assign w_tick  = (r_fcnt == c_last_cyc);
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_SLEW);
    assign w_xfer  = cmd.cmd_valid && w_ready;

    assign w_cmd_clamped = ({1'b0, cmd.cmd_duty} > c_dmax) ? c_dmax[DW-1:0] : cmd.cmd_duty;

    // One slew step in DW+1 bits; the target is already clamped so moving up
    // can never pass DMAX, and moving down by a full step only happens when
    // cur is more than MAX_STEP above target, so it cannot go below zero.
    always_comb begin
        w_cur_x  = {1'b0, r_cur};
        w_tgt_x  = {1'b0, r_target};
        w_step_x = w_cur_x;
        if (w_tgt_x > w_cur_x) begin
            if ((w_tgt_x - w_cur_x) <= c_max_step) begin
                w_step_x = w_tgt_x;
            end else begin
                w_step_x = w_cur_x + c_max_step;
            end
        end else begin
            if ((w_cur_x - w_tgt_x) <= c_max_step) begin
                w_step_x = w_tgt_x;
            end else begin
                w_step_x = w_cur_x - c_max_step;
            end
        end
    end

    assign w_cur_step = w_step_x[DW-1:0];
    assign w_reached  = (w_cur_step == r_target);

    for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
        assign w_d_n_nxt[gi*DW +: DW] = r_pend_en[gi] ? w_cur_step : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_tick) begin
                    w_apply     = 1'b1;
                    w_state_nxt = w_reached ? ST_IDLE : ST_SLEW;
                end
            end
            ST_SLEW: begin
                if (w_tick) begin
                    w_apply = 1'b1;
                    // A command landing on the tick edge needs its own frame
                    // to apply its enable mask if the old ramp just finished.
                    if (w_xfer) begin
                        w_state_nxt = w_reached ? ST_WAIT : ST_SLEW;
                    end else if (w_reached) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fcnt     <= 3'd0;
            r_cur      <= '0;
            r_target   <= '0;
            r_pend_en  <= '0;
            r_phase_en <= '0;
            r_d_n      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= r_fcnt + 3'd1;
            if (w_xfer) begin
                r_target  <= w_cmd_clamped;
                r_pend_en <= cmd.cmd_phase_en;
            end
            if (w_apply) begin
                r_cur      <= w_cur_step;
                r_phase_en <= r_pend_en;
                r_d_n      <= w_d_n_nxt;
            end
        end
    end

    assign cmd.cmd_ready = w_ready;
    assign d_n_out       = r_d_n;
    assign phase_en_out  = r_phase_en;
    assign frame_tick    = w_tick;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/dither_duty_sched.md
# dither_duty_sched

Duty-command scheduler for the multi-phase dither stage. It accepts duty commands from the SPI/compensator side over a valid/ready handshake. It slew-limits each command and distributes the result to NPH per-phase 10-bit duty buses, each of which drives one dither instance. All updates land on an 8-cycle dither frame boundary, so a dither pattern is never switched mid-frame.

## Interface
- NPH, 4, number of phases / dither instances driven
- DW, 10, duty word width (matches dither d_n_input)
- MAX_STEP, 8, maximum duty change (LSBs) applied per frame
- DMAX, 1000, upper clamp on commanded duty
- clk_in  input  1  clock, shared with all dither instances
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  scheduler can accept a command
- cmd_duty  input  DW  target duty
- cmd_phase_en  input  NPH  requested phase-enable mask
- d_n_out  output  NPH*DW  per-phase duty; phase i occupies bits [i*DW +: DW]
- phase_en_out  output  NPH  applied phase-enable mask
- frame_tick  output  1  high during the last cycle of each 8-cycle frame
- busy  output  1  state != IDLE

## Operation
- Frame counter fcnt: 3 bits, free-running, resets to 0, increments every clk_in, wraps 7->0. Its phase is identical to the dither's internal counter because both are released by the same rst.
- frame_tick = (fcnt==7). It is combinational from the register.
- Handshake: a transfer occurs when cmd_valid & cmd_ready on a rising edge. cmd_ready = (state==IDLE) | (state==SLEW).
- On transfer: the target register takes min(cmd_duty, DMAX), and pend_en takes cmd_phase_en.
- State machine with three states:
  - IDLE: on transfer -> WAIT.
  - WAIT: wait for frame_tick. At that edge apply one step and load phase_en_out <= pend_en. If cur==target after the step -> IDLE, else -> SLEW.
  - SLEW: at each frame_tick apply one step. If cur==target after the step -> IDLE.
  - SLEW also accepts commands. An accepted command retargets the ramp and updates pend_en; the new pend_en is applied at the next frame_tick.
- Step rule: if |target-cur| <= MAX_STEP, then cur <= target; otherwise cur moves MAX_STEP toward target. Arithmetic uses DW+1 bits, with no wrap below 0 and none above DMAX.
- Output rule: d_n_out[i] = cur when phase_en_out[i], else 0. d_n_out is registered and changes only on the frame_tick edge.

## Timing
- Reset values:
  - state IDLE, fcnt 0, cur 0, target 0, pend_en 0.
  - d_n_out all 0, phase_en_out 0, busy 0, frame_tick 0, cmd_ready 1.
- Latency: a command accepted at any cycle of a frame takes effect at the next frame_tick edge. Dither first sees the new value at fcnt==0.
- If a transfer coincides with frame_tick in IDLE, the step is not taken that edge; the first step is at the following frame_tick (8 cycles later).
- If a transfer coincides with frame_tick in SLEW, the step uses the old target and the new target is captured. The state stays SLEW unless cur==old target after that step, in which case it goes to WAIT.
- A command equal to cur still passes through WAIT. It updates phase_en_out at the next frame_tick, then returns to IDLE.
- Enable/disable edges are frame-aligned: a newly enabled phase gets cur, a disabled phase gets 0, both at the same edge.
- rst asserted mid-ramp: all registers return to reset values immediately, and any in-flight command is discarded.
- cmd_valid held high in WAIT is not accepted (cmd_ready=0). It is accepted on the first IDLE/SLEW cycle.

## Test plan
- Reset then idle: after rst release, d_n_out=0, cmd_ready=1, and frame_tick pulses at cycles 7, 15, 23.
- Ramp up: at cur 0, cmd 100 with mask 4'b1111 -> all four phases read 8, 16, …, 96, 100 at successive frame_tick edges (13 steps). busy drops after the value 100 is reached.
- Clamp and ramp down: cmd 1023 -> target 1000. Then cmd 990 -> a single step to 990 at the next frame_tick.
- Mid-ramp retarget: while ramping 0->200, accept cmd 40 when cur=64 -> next frame cur=56, then 48, then 40, then IDLE.
- Phase shedding: at cur 300 with mask 4'b1111, cmd 300 with mask 4'b0011 -> phases 2 and 3 go to 0 exactly at the next frame_tick edge. Phases 0 and 1 stay 300 and are never off-boundary.
- Async reset mid-ramp: assert rst when cur=48 -> all outputs are 0 with no clock edge needed. After release, ramping restarts only on a new command.
